// File: rtl/mouse_cursor_tracker_pkg.sv
// Shared constants, framer state encoding and PS/2 flag-bit indices for the mouse cursor tracker.
package mouse_cursor_tracker_pkg;

  localparam int unsigned ScreenW    = 640;
  localparam int unsigned ScreenH    = 480;
  localparam int unsigned CursorW    = 100;
  localparam int unsigned CursorH    = 80;
  localparam int unsigned InitX      = 320;
  localparam int unsigned InitY      = 240;
  localparam int unsigned TimeoutCyc = 2_500_000;

  localparam int unsigned FlagBtnL = 0;
  localparam int unsigned FlagBtnR = 1;
  localparam int unsigned FlagSync = 3;
  localparam int unsigned FlagXs   = 4;
  localparam int unsigned FlagYs   = 5;
  localparam int unsigned FlagXo   = 6;
  localparam int unsigned FlagYo   = 7;

  typedef enum logic [1:0] {
    StB0    = 2'd0,
    StB1    = 2'd1,
    StB2    = 2'd2,
    StApply = 2'd3
  } frame_state_e;

  // Saturate a signed 12-bit candidate position into 0..max_v.
  function automatic logic [9:0] clamp_pos(input logic signed [11:0] v, input logic [9:0] max_v);
    if (v < 0) return '0;
    if (v > $signed({2'b00, max_v})) return max_v;
    return v[9:0];
  endfunction

endpackage

// File: rtl/mouse_cursor_tracker_if.sv
// Byte input and cursor/button output bundle between the PS/2 receiver, the tracker and its users.
interface mouse_cursor_tracker_if;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       btn_left;
  logic       btn_right;
  logic       click_l;
  logic       pkt_valid;
  logic [7:0] sync_err;

  modport master (
    output byte_data, byte_ready,
    input  posx, posy, btn_left, btn_right, click_l, pkt_valid, sync_err
  );

  modport slave (
    input  byte_data, byte_ready,
    output posx, posy, btn_left, btn_right, click_l, pkt_valid, sync_err
  );
endinterface

// File: rtl/mouse_cursor_tracker_framer.sv
// Frames the PS/2 byte stream into 3-byte mouse packets with resync, inter-byte timeout
// and a saturating error count.
module mouse_cursor_tracker_framer
  import mouse_cursor_tracker_pkg::*;
#(
  parameter int unsigned Timeout = TimeoutCyc
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_ready,
  output logic [7:0] flags,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       frame_valid,
  output logic [7:0] sync_err
);

  localparam int unsigned TimerW = $clog2(Timeout + 1);

  frame_state_e      state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        flags_q, flags_d, x_q, x_d, y_q, y_d;
  logic [7:0]        sync_err_q, sync_err_d;
  logic              byte_ready_q;
  logic              new_byte, bump_err, timed_out;

  assign new_byte  = byte_ready & ~byte_ready_q;
  assign timed_out = (timer_q == TimerW'(Timeout - 1));

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    x_d      = x_q;
    y_d      = y_q;
    timer_d  = '0;
    bump_err = 1'b0;
    unique case (state_q)
      StB0: begin
        if (new_byte) begin
          if (byte_data[FlagSync]) begin
            flags_d = byte_data;
            state_d = StB1;
          end else begin
            bump_err = 1'b1;
          end
        end
      end
      StB1, StB2: begin
        // A byte arriving on the timeout cycle still counts.
        if (new_byte) begin
          if (state_q == StB1) begin
            x_d     = byte_data;
            state_d = StB2;
          end else begin
            y_d     = byte_data;
            state_d = StApply;
          end
        end else if (timed_out) begin
          state_d  = StB0;
          bump_err = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StApply: state_d = StB0;
      default: state_d = StB0;
    endcase
    sync_err_d = (bump_err && sync_err_q != 8'hFF) ? sync_err_q + 8'd1 : sync_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StB0;
      timer_q      <= '0;
      flags_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      sync_err_q   <= '0;
      byte_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      flags_q      <= flags_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sync_err_q   <= sync_err_d;
      byte_ready_q <= byte_ready;
    end
  end

  assign flags       = flags_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_valid = (state_q == StApply);
  assign sync_err    = sync_err_q;

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Applies framed PS/2 mouse packets to a clamped cursor position and tracks button state.
module mouse_cursor_tracker
  import mouse_cursor_tracker_pkg::*;
#(
  parameter int unsigned ScreenWP   = ScreenW,
  parameter int unsigned ScreenHP   = ScreenH,
  parameter int unsigned CursorWP   = CursorW,
  parameter int unsigned CursorHP   = CursorH,
  parameter int unsigned InitXP     = InitX,
  parameter int unsigned InitYP     = InitY,
  parameter int unsigned TimeoutCyc = mouse_cursor_tracker_pkg::TimeoutCyc
) (
  input  logic                  clk,
  input  logic                  rst,
  mouse_cursor_tracker_if.slave bus
);

  localparam logic [9:0] MaxX = 10'(ScreenWP - CursorWP);
  localparam logic [9:0] MaxY = 10'(ScreenHP - CursorHP);

  logic [7:0]         flags, x, y;
  logic               frame_valid;
  logic signed [8:0]  dx, dy;
  logic signed [11:0] nx, ny;
  logic [9:0]         posx_q;
  logic [8:0]         posy_q;
  logic               btn_left_q, btn_right_q, click_q, pkt_valid_q;
  logic               unused_flags;

  mouse_cursor_tracker_framer #(
    .Timeout(TimeoutCyc)
  ) u_framer (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (bus.byte_data),
    .byte_ready (bus.byte_ready),
    .flags      (flags),
    .x          (x),
    .y          (y),
    .frame_valid(frame_valid),
    .sync_err   (bus.sync_err)
  );

  assign unused_flags = ^{flags[2], flags[FlagSync]};

  // PS/2 Y grows upward while screen Y grows downward, hence the subtraction.
  always_comb begin
    dx = flags[FlagXo] ? 9'sd0 : $signed({flags[FlagXs], x});
    dy = flags[FlagYo] ? 9'sd0 : $signed({flags[FlagYs], y});
    nx = $signed({2'b00, posx_q}) + 12'(dx);
    ny = $signed({3'b000, posy_q}) - 12'(dy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      posx_q      <= 10'(InitXP);
      posy_q      <= 9'(InitYP);
      btn_left_q  <= 1'b0;
      btn_right_q <= 1'b0;
      click_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
    end else begin
      pkt_valid_q <= frame_valid;
      click_q     <= frame_valid & flags[FlagBtnL] & ~btn_left_q;
      if (frame_valid) begin
        posx_q      <= clamp_pos(nx, MaxX);
        posy_q      <= 9'(clamp_pos(ny, MaxY));
        btn_left_q  <= flags[FlagBtnL];
        btn_right_q <= flags[FlagBtnR];
      end
    end
  end

  assign bus.posx      = posx_q;
  assign bus.posy      = posy_q;
  assign bus.btn_left  = btn_left_q;
  assign bus.btn_right = btn_right_q;
  assign bus.click_l   = click_q;
  assign bus.pkt_valid = pkt_valid_q;

endmodule
